// File: rtl/fpu_pkg.sv
// Shared types and widths for the fpu issue/capture wrapper.
// Opcode encodings match the fpu datapath's operation select.
package fpu_pkg;
  localparam int FLT_W = 32;
  localparam int OP_W  = 2;
  localparam int REQ_W = 2 * FLT_W + OP_W;
  localparam int RES_W = FLT_W + OP_W;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } fpu_op_e;
endpackage

// File: rtl/fpu_sync_fifo.sv
// Single-clock FIFO with registered storage and combinational head read.
// Push when full and pop when empty are ignored.
module fpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Flow-controlled wrapper around a fixed-latency fpu: request FIFO -> issue
// registers -> latency pipe -> in-order result FIFO, with credit-based issue.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int FPU_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FLT_W-1:0] req_a,
  input  logic [FLT_W-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic [FLT_W-1:0] fpu_a,
  output logic [FLT_W-1:0] fpu_b,
  output logic [OP_W-1:0]  fpu_op,
  input  logic [FLT_W-1:0] fpu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FLT_W-1:0] res_data,
  output logic [OP_W-1:0]  res_op,
  output logic             busy
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid, and valid holds until the transfer.
  localparam int RQ_CW = $clog2(REQ_DEPTH) + 1;
  localparam int RS_CW = $clog2(RES_DEPTH) + 1;
  localparam int USE_W = $clog2(RES_DEPTH + FPU_LAT + 1) + 1;

  logic             w_req_push;
  logic             w_req_full;
  logic             w_req_empty;
  logic [RQ_CW-1:0] w_req_count;
  logic [REQ_W-1:0] w_req_head;
  logic             w_issue;
  logic             w_res_push;
  logic             w_res_pop;
  logic             w_res_full;
  logic             w_res_empty;
  logic [RS_CW-1:0] w_res_count;
  logic [RES_W-1:0] w_res_head;
  logic [USE_W-1:0] w_inflight;
  logic [USE_W-1:0] w_used;

  logic [FLT_W-1:0] r_fpu_a;
  logic [FLT_W-1:0] r_fpu_b;
  logic [OP_W-1:0]  r_fpu_op;
  logic [FPU_LAT:0] r_pipe_v;
  logic [OP_W-1:0]  r_pipe_op [FPU_LAT+1];

  assign req_ready  = (w_req_count < RQ_CW'(REQ_DEPTH));
  assign w_req_push = req_valid && req_ready;

  fpu_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_req_push),
    .i_wdata ({req_a, req_b, req_op}),
    .i_pop   (w_issue),
    .o_rdata (w_req_head),
    .o_full  (w_req_full),
    .o_empty (w_req_empty),
    .o_count (w_req_count)
  );

  // Every valid pipe stage, including the one being captured this cycle,
  // still owns a result slot that res_count does not yet show.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= FPU_LAT; i++) w_inflight = w_inflight + USE_W'(r_pipe_v[i]);
  end

  assign w_used  = USE_W'(w_res_count) + w_inflight;
  assign w_issue = !w_req_empty && (w_used < USE_W'(RES_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpu_a  <= '0;
      r_fpu_b  <= '0;
      r_fpu_op <= '0;
      r_pipe_v <= '0;
      for (int i = 0; i <= FPU_LAT; i++) r_pipe_op[i] <= '0;
    end else begin
      if (w_issue) {r_fpu_a, r_fpu_b, r_fpu_op} <= w_req_head;
      r_pipe_v     <= {r_pipe_v[FPU_LAT-1:0], w_issue};
      r_pipe_op[0] <= w_req_head[OP_W-1:0];
      for (int i = 1; i <= FPU_LAT; i++) r_pipe_op[i] <= r_pipe_op[i-1];
    end
  end

  assign fpu_a  = r_fpu_a;
  assign fpu_b  = r_fpu_b;
  assign fpu_op = r_fpu_op;

  assign w_res_push = r_pipe_v[FPU_LAT];
  assign w_res_pop  = !w_res_empty && res_ready;

  fpu_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_res_push),
    .i_wdata ({fpu_out, r_pipe_op[FPU_LAT]}),
    .i_pop   (w_res_pop),
    .o_rdata (w_res_head),
    .o_full  (w_res_full),
    .o_empty (w_res_empty),
    .o_count (w_res_count)
  );

  assign res_valid = !w_res_empty;
  assign res_data  = w_res_head[RES_W-1:OP_W];
  assign res_op    = w_res_head[OP_W-1:0];
  assign busy      = !w_req_empty || (|r_pipe_v) || !w_res_empty;

  a_no_res_overflow: assert property (@(posedge clk) disable iff (rst) !(w_res_push && w_res_full));
  a_req_full_blocks: assert property (@(posedge clk) disable iff (rst) !(w_req_full && req_ready));
endmodule
